// File: rtl/dcache_mem_stage_if.sv
// -----------------------------------------------------------------------------
// dcache_mem_stage_if
// Bundles the MEM-stage CPU port, the backing-memory port and the statistics
// counters of the data cache controller.
//
//   slave  : the cache controller itself (consumes CPU/memory inputs).
//   master : the surrounding pipeline + memory system (drives them).
//
// Signals
//   cpu_read / cpu_write   MemRead / MemWrite from the MEM control register
//   cpu_addr / cpu_wdata   word address and store data
//   cpu_rdata              load data, valid in the cycle a read completes
//   stall                  freezes PC, pipeline and control registers
//   mem_req / mem_we       memory request; 1 = word write, 0 = line read
//   mem_addr / mem_wdata   request address and write data
//   mem_rdata              4-word line, word k in [16k+15:16k]
//   mem_ready              one-cycle completion pulse
//   hit_count / miss_count saturating read hit / miss counters
// -----------------------------------------------------------------------------
interface dcache_mem_stage_if #(
    parameter int WORD_SIZE = 16
);
    logic                   cpu_read;
    logic                   cpu_write;
    logic [WORD_SIZE-1:0]   cpu_addr;
    logic [WORD_SIZE-1:0]   cpu_wdata;
    logic [WORD_SIZE-1:0]   cpu_rdata;
    logic                   stall;
    logic                   mem_req;
    logic                   mem_we;
    logic [WORD_SIZE-1:0]   mem_addr;
    logic [WORD_SIZE-1:0]   mem_wdata;
    logic [4*WORD_SIZE-1:0] mem_rdata;
    logic                   mem_ready;
    logic [15:0]            hit_count;
    logic [15:0]            miss_count;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/dcache_mem_stage.sv
// -----------------------------------------------------------------------------
// dcache_mem_stage
// Direct-mapped, write-through, no-write-allocate data cache in the MEM stage.
// Read hits complete combinationally with no stall. Read misses fetch a whole
// line from memory; writes always go to memory as a single word and update
// the cached copy only when the address is already resident.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      dcache_mem_stage_if.slave (CPU side, memory side, counters)
// -----------------------------------------------------------------------------
module dcache_mem_stage #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    dcache_mem_stage_if.slave  bus
);
    localparam int OFF_W = 2;                  // 4 words per line
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_e;

    state_e               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];

    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [WORD_SIZE-1:0] mem_addr_q;
    logic [WORD_SIZE-1:0] mem_wdata_q;
    logic [15:0]          hit_count_q,  hit_count_d;
    logic [15:0]          miss_count_q, miss_count_d;

    // Address decomposition; cpu_* are held stable by the pipeline while stalled.
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;

    assign off = bus.cpu_addr[OFF_W-1:0];
    assign idx = bus.cpu_addr[OFF_W +: IDX_W];
    assign tag = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    // Incoming line split into words.
    logic [WORD_SIZE-1:0] fill_words [LINE_WORDS];

    always_comb begin
        for (int k = 0; k < LINE_WORDS; k++) begin
            fill_words[k] = bus.mem_rdata[k*WORD_SIZE +: WORD_SIZE];
        end
    end

    // Saturating increments.
    assign hit_count_d  = (hit_count_q  == 16'hFFFF) ? hit_count_q  : hit_count_q  + 16'd1;
    assign miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;

    // Combinational stall and load data.
    logic                 stall;
    logic [WORD_SIZE-1:0] cpu_rdata;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stall     = 1'b0;
        cpu_rdata = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_write) begin
                    stall = 1'b1;                     // write wins over a read
                end else if (bus.cpu_read) begin
                    if (hit) cpu_rdata = data_q[idx][off];
                    else     stall     = 1'b1;
                end
            end
            FETCH: begin
                stall = !bus.mem_ready;
                if (bus.mem_ready) cpu_rdata = fill_words[off];  // forward the fill
            end
            WRITE: begin
                stall = !bus.mem_ready;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Control FSM with registered memory-request outputs.
    // NOTE: sequential state is assigned with <= so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cpu_write) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.cpu_addr;
                        mem_wdata_q <= bus.cpu_wdata;
                    end else if (bus.cpu_read) begin
                        if (hit) begin
                            hit_count_q <= hit_count_d;
                        end else begin
                            state_q      <= FETCH;
                            mem_req_q    <= 1'b1;
                            mem_we_q     <= 1'b0;
                            mem_addr_q   <= {bus.cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                            miss_count_q <= miss_count_d;
                        end
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        state_q      <= IDLE;
                        valid_q[idx] <= 1'b1;
                        mem_req_q    <= 1'b0;
                        mem_addr_q   <= '0;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays.
    // NOTE: arrays are not reset; valid_q alone decides whether contents are used.
    always_ff @(posedge clk) begin
        if (state_q == FETCH && bus.mem_ready) begin
            tag_q[idx] <= tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                data_q[idx][k] <= fill_words[k];
            end
        end else if (state_q == WRITE && bus.mem_ready && hit) begin
            data_q[idx][off] <= bus.cpu_wdata;       // write-through update, no allocate
        end
    end

    assign bus.stall      = stall;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_dcache_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_dcache_mem_stage
// Directed testbench for dcache_mem_stage. A hand-driven memory responder
// raises mem_ready L cycles after mem_req rises; expected values are worked
// out by hand from the address split (offset [1:0], index [4:2], tag [15:5]).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcache_mem_stage;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    dcache_mem_stage_if #(.WORD_SIZE(16)) bus ();

    dcache_mem_stage #(
        .WORD_SIZE (16),
        .NUM_LINES (8),
        .LINE_WORDS(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] LINE_A = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] LINE_B = 64'h0003_0002_0001_5555;
    localparam logic [63:0] LINE_C = 64'h9999_8888_7777_6666;

    // Results of one access.
    int          r_stall, r_req;
    logic [15:0] r_rdata, r_addr, r_wdata;
    logic        r_we, r_stable, r_req_after, r_timeout;

    // Runs one access starting just after a rising edge. mem_ready is raised
    // lat cycles after mem_req rises. Ends just after the edge that retires it.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [63:0] line, input int lat);
        int   cyc;
        logic done;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.mem_rdata = line;
        r_stall = 0; r_req = 0; r_rdata = '0; r_addr = '0; r_wdata = '0;
        r_we = 1'b0; r_stable = 1'b1; r_timeout = 1'b0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 50) begin
            if (bus.mem_req) begin
                r_req++;
                if (r_req == 1) begin
                    r_addr  = bus.mem_addr;
                    r_we    = bus.mem_we;
                    r_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== r_addr || bus.mem_we !== r_we ||
                             bus.mem_wdata !== r_wdata) begin
                    r_stable = 1'b0;
                end
                bus.mem_ready = (r_req == lat + 1);
            end else begin
                bus.mem_ready = 1'b0;
            end
            @(negedge clk);
            if (bus.stall) r_stall++;
            else begin
                done    = 1'b1;
                r_rdata = bus.cpu_rdata;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        r_timeout     = !done;
        bus.mem_ready = 1'b0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        r_req_after   = bus.mem_req;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.mem_req, bus.mem_we} !== 2'b00) begin
            fails++; $display("FAIL reset_req_we got=%b exp=00", {bus.mem_req, bus.mem_we});
        end
        tests++;
        if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            fails++; $display("FAIL reset_addr_wdata got=%h/%h exp=0000/0000", bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if (bus.hit_count !== 16'h0 || bus.miss_count !== 16'h0) begin
            fails++; $display("FAIL reset_counters got=%h/%h exp=0000/0000", bus.hit_count, bus.miss_count);
        end
        @(negedge clk);
        tests++;
        if (bus.stall !== 1'b0 || bus.cpu_rdata !== 16'h0) begin
            fails++; $display("FAIL reset_stall_rdata got=%b/%h exp=0/0000", bus.stall, bus.cpu_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_miss();
        run_access(1'b1, 1'b0, 16'h0012, 16'h0, LINE_A, 3);
        tests++;
        if (r_timeout) begin fails++; $display("FAIL miss_timeout got=timeout exp=done"); end
        tests++;
        if (r_stall != 4) begin fails++; $display("FAIL miss_stall got=%0d exp=4", r_stall); end
        tests++;
        if (r_addr !== 16'h0010 || r_we !== 1'b0) begin
            fails++; $display("FAIL miss_req got=%h/%b exp=0010/0", r_addr, r_we);
        end
        tests++;
        if (r_rdata !== 16'hCCCC) begin fails++; $display("FAIL miss_rdata got=%h exp=cccc", r_rdata); end
        tests++;
        if (!r_stable) begin fails++; $display("FAIL miss_req_stable got=unstable exp=stable"); end
        tests++;
        if (r_req_after !== 1'b0) begin fails++; $display("FAIL miss_req_after got=%b exp=0", r_req_after); end
        tests++;
        if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
            fails++; $display("FAIL miss_counts got=%0d/%0d exp=0/1", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_read_hit();
        run_access(1'b1, 1'b0, 16'h0013, 16'h0, 64'h0, 0);
        tests++;
        if (r_stall != 0 || r_req != 0) begin
            fails++; $display("FAIL hit_stall_req got=%0d/%0d exp=0/0", r_stall, r_req);
        end
        tests++;
        if (r_rdata !== 16'hDDDD) begin fails++; $display("FAIL hit_rdata got=%h exp=dddd", r_rdata); end
        tests++;
        if (bus.hit_count !== 16'd1 || bus.miss_count !== 16'd1) begin
            fails++; $display("FAIL hit_counts got=%0d/%0d exp=1/1", bus.hit_count, bus.miss_count);
        end
    endtask

    // Read and write asserted together: the write wins, counters do not move.
    task automatic test_write_hit();
        run_access(1'b1, 1'b1, 16'h0011, 16'h1234, 64'h0, 2);
        tests++;
        if (r_stall != 3) begin fails++; $display("FAIL whit_stall got=%0d exp=3", r_stall); end
        tests++;
        if (r_addr !== 16'h0011 || r_we !== 1'b1 || r_wdata !== 16'h1234) begin
            fails++; $display("FAIL whit_req got=%h/%b/%h exp=0011/1/1234", r_addr, r_we, r_wdata);
        end
        tests++;
        if (!r_stable || r_rdata !== 16'h0) begin
            fails++; $display("FAIL whit_stable_rdata got=%b/%h exp=1/0000", r_stable, r_rdata);
        end
        tests++;
        if (bus.hit_count !== 16'd1 || bus.miss_count !== 16'd1) begin
            fails++; $display("FAIL whit_counts got=%0d/%0d exp=1/1", bus.hit_count, bus.miss_count);
        end
        run_access(1'b1, 1'b0, 16'h0011, 16'h0, 64'h0, 0);
        tests++;
        if (r_stall != 0 || r_rdata !== 16'h1234 || bus.hit_count !== 16'd2) begin
            fails++; $display("FAIL whit_readback got=%0d/%h/%0d exp=0/1234/2", r_stall, r_rdata, bus.hit_count);
        end
    endtask

    task automatic test_write_miss();
        run_access(1'b0, 1'b1, 16'h0100, 16'h5555, 64'h0, 1);
        tests++;
        if (r_stall != 2 || r_addr !== 16'h0100 || r_we !== 1'b1 || r_wdata !== 16'h5555) begin
            fails++; $display("FAIL wmiss_req got=%0d/%h/%b/%h exp=2/0100/1/5555", r_stall, r_addr, r_we, r_wdata);
        end
        run_access(1'b1, 1'b0, 16'h0100, 16'h0, LINE_B, 1);
        tests++;
        if (r_stall != 2 || r_addr !== 16'h0100 || r_we !== 1'b0) begin
            fails++; $display("FAIL wmiss_noalloc got=%0d/%h/%b exp=2/0100/0", r_stall, r_addr, r_we);
        end
        tests++;
        if (r_rdata !== 16'h5555 || bus.miss_count !== 16'd2) begin
            fails++; $display("FAIL wmiss_read got=%h/%0d exp=5555/2", r_rdata, bus.miss_count);
        end
    endtask

    // 0x0091 shares index 4 with 0x0012 but has a different tag.
    task automatic test_evict();
        run_access(1'b1, 1'b0, 16'h0091, 16'h0, LINE_C, 2);
        tests++;
        if (r_stall != 3 || r_addr !== 16'h0090 || r_rdata !== 16'h7777) begin
            fails++; $display("FAIL evict_fill got=%0d/%h/%h exp=3/0090/7777", r_stall, r_addr, r_rdata);
        end
        run_access(1'b1, 1'b0, 16'h0012, 16'h0, LINE_A, 0);
        tests++;
        if (r_stall != 1 || r_req != 1 || r_rdata !== 16'hCCCC) begin
            fails++; $display("FAIL evict_refetch got=%0d/%0d/%h exp=1/1/cccc", r_stall, r_req, r_rdata);
        end
        tests++;
        if (bus.miss_count !== 16'd4 || bus.hit_count !== 16'd2) begin
            fails++; $display("FAIL evict_counts got=%0d/%0d exp=2/4", bus.hit_count, bus.miss_count);
        end
        // Back-to-back: next access issued in the cycle right after mem_ready.
        run_access(1'b1, 1'b0, 16'h0013, 16'h0, 64'h0, 0);
        tests++;
        if (r_stall != 0 || r_rdata !== 16'hDDDD || bus.hit_count !== 16'd3) begin
            fails++; $display("FAIL b2b_hit got=%0d/%h/%0d exp=0/dddd/3", r_stall, r_rdata, bus.hit_count);
        end
    endtask

    task automatic test_idle_ready();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.stall !== 1'b0 || bus.cpu_rdata !== 16'h0) begin
            fails++; $display("FAIL idle_ready_comb got=%b/%h exp=0/0000", bus.stall, bus.cpu_rdata);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        tests++;
        if (bus.mem_req !== 1'b0 || bus.hit_count !== 16'd3 || bus.miss_count !== 16'd4) begin
            fails++; $display("FAIL idle_ready_state got=%b/%0d/%0d exp=0/3/4", bus.mem_req, bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bus.cpu_read  = 1'b1;
        bus.cpu_addr  = 16'h0040;
        bus.mem_rdata = LINE_A;
        @(posedge clk);
        #1;
        tests++;
        if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rst_fetch_started got=%b exp=1", bus.mem_req); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0) begin
            fails++; $display("FAIL rst_async got=%b/%0d/%0d exp=0/0/0", bus.mem_req, bus.hit_count, bus.miss_count);
        end
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        bus.cpu_read  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || bus.miss_count !== 16'd0) begin
            fails++; $display("FAIL rst_ready_ignored got=%b/%0d exp=0/0", bus.mem_req, bus.miss_count);
        end
        run_access(1'b1, 1'b0, 16'h0012, 16'h0, LINE_A, 1);
        tests++;
        if (r_stall != 2 || r_rdata !== 16'hCCCC || bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
            fails++; $display("FAIL rst_refetch got=%0d/%h/%0d/%0d exp=2/cccc/1/0",
                              r_stall, r_rdata, bus.miss_count, bus.hit_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_evict();
        test_idle_ready();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
